// File: rtl/regfile_wb_queue_if.sv
// Producer-side request bundle and register-file write-port bundle for regfile_wb_queue.
// Latency: none (wiring only).
// Backpressure: src_ready from the queue, stall from the register-file side.
// Ports: src_valid/src_ready/src_addr/src_data (per producer), stall,
//        waddr/wen/wdata (registered write port), count/full/empty (occupancy).
interface regfile_wb_queue_if #(
  parameter int WIDTH = 32,
  parameter int N_REG = 32,
  parameter int N_SRC = 2,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(N_REG);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N_SRC-1:0]            src_valid;
  logic [N_SRC-1:0]            src_ready;
  logic [N_SRC-1:0][AW-1:0]    src_addr;
  logic [N_SRC-1:0][WIDTH-1:0] src_data;
  logic                        stall;
  logic [AW-1:0]               waddr;
  logic                        wen;
  logic [WIDTH-1:0]            wdata;
  logic [CW-1:0]               count;
  logic                        full;
  logic                        empty;

  // master: producers plus register-file side driving the queue
  modport master (
    output src_valid, src_addr, src_data, stall,
    input  src_ready, waddr, wen, wdata, count, full, empty
  );

  // slave: the write-back queue itself
  modport slave (
    input  src_valid, src_addr, src_data, stall,
    output src_ready, waddr, wen, wdata, count, full, empty
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// Write-back queue: round-robin arbitrates N_SRC producers into an in-order FIFO feeding one RF write port.
// Latency: accepted at edge k -> wen/waddr/wdata visible after edge k+1 at the earliest.
// Backpressure: src_ready drops to zero while full; stall holds the head entry and deasserts wen.
// Ports: clk, rst_n (async active-low); wb (slave modport of regfile_wb_queue_if) carrying
//        producer requests, stall, registered write port and occupancy flags.
// The interface instance must be built with the same WIDTH/N_REG/N_SRC/DEPTH as this module.
module regfile_wb_queue #(
  parameter int WIDTH = 32,
  parameter int N_REG = 32,
  parameter int N_SRC = 2,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_wb_queue_if.slave wb
);
  localparam int AW = $clog2(N_REG);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int RW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int EW = AW + WIDTH;

  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [RW-1:0]    rr_ptr;

  logic             wen_q;
  logic [AW-1:0]    waddr_q;
  logic [WIDTH-1:0] wdata_q;

  logic             full_w;
  logic             empty_w;
  logic             gnt_vld;
  logic [RW-1:0]    gnt_idx;
  logic [N_SRC-1:0] rdy;
  logic             push;
  logic             pop;
  logic [EW-1:0]    push_ent;

  // Flags come from the registered occupancy only, so there is no input-to-flag path.
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // Round-robin search starting at rr_ptr; the first valid source wins.
  // Nothing is granted while full, even if the head pops this cycle.
  always_comb begin
    int          idx;
    logic [RW-1:0] idx_r;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rdy     = '0;
    idx     = 0;
    idx_r   = '0;
    if (!full_w) begin
      for (int k = 0; k < N_SRC; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_SRC) idx = idx - N_SRC;
        idx_r = RW'(idx);
        if (!gnt_vld && wb.src_valid[idx_r]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx_r;
        end
      end
    end
    if (gnt_vld) rdy[gnt_idx] = 1'b1;
  end

  assign push     = gnt_vld;
  assign pop      = !empty_w && !wb.stall;
  assign push_ent = {wb.src_addr[gnt_idx], wb.src_data[gnt_idx]};

  // Entry storage needs no reset: only slots between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rr_ptr  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (gnt_idx == RW'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered write port: address/data hold their last value when nothing drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (pop) begin
      wen_q              <= 1'b1;
      {waddr_q, wdata_q} <= mem[rd_ptr];
    end else begin
      wen_q <= 1'b0;
    end
  end

  assign wb.src_ready = rdy;
  assign wb.wen       = wen_q;
  assign wb.waddr     = waddr_q;
  assign wb.wdata     = wdata_q;
  assign wb.count     = count_q;
  assign wb.full      = full_w;
  assign wb.empty     = empty_w;
endmodule
